preset_editor: RTL and testbench
================================

Name: preset_editor

Overview:
- Button-driven front end that generates the `preset`, `load` and `EN` inputs consumed by the stopwatch counter chain.
- The user selects a digit, steps its value, commits it with a load pulse, and starts or stops counting.
- Also drives `edit_pos` and `blink` so the display block can flash the digit under edit.
- Runs entirely in the `clk_1Khz` domain.

Parameters:
- DEBOUNCE_MS, 20: cycles (ms) a synchronized key level must hold before it is accepted.
- LOAD_CYCLES, 1: width of the `load` pulse in cycles (range 1..15).
- BLINK_HALF, 250: half-period of `blink` in cycles.

Ports:
- clk_1Khz, input, 1: 1 kHz system clock; all logic on its rising edge.
- rst, input, 1: reset, asynchronous and active-low.
- key_start, input, 1: raw start/stop button, active-high, asynchronous.
- key_mode, input, 1: raw edit-enter/commit button, active-high.
- key_next, input, 1: raw digit-select button, active-high.
- key_inc, input, 1: raw digit-increment button, active-high.
- preset, output, 28: {m1,m0,s1,s0,ms2,ms1,ms0}, 4-bit BCD each, m1 in [27:24].
- load, output, 1: high for LOAD_CYCLES cycles on commit.
- EN, output, 1: count enable to the counter chain.
- editing, output, 1: high while in EDIT.
- edit_pos, output, 3: digit under edit; 6 = m1 ... 0 = ms0.
- blink, output, 1: flash strobe for the display.

Behaviour:
- Reset (rst=0, async) clears `preset` to 28'h0000000, `load`, `EN`, `editing` and `blink` to 0, and sets `edit_pos` to 6 and the state to STOP. `load` drops immediately, even mid-COMMIT.
- Key conditioning, identical per key:
  - 2-FF synchronizer, then a stability counter.
  - The debounced level changes only after the synchronized level differs from it for DEBOUNCE_MS consecutive cycles; any glitch restarts the count.
  - A 0->1 change of the debounced level makes a 1-cycle press pulse. Release makes no event.
- Priority of press pulses in one cycle: mode > start > next > inc. Only the highest is acted on; the rest are discarded, not queued.
- Actions register on the clock edge where the press pulse is high.
- FSM states STOP, RUN, EDIT, COMMIT:
  - STOP: EN=0. start -> RUN. mode -> EDIT with edit_pos=6. next and inc are ignored.
  - RUN: EN=1. start -> STOP. mode, next and inc are ignored; an edit cannot be entered while counting.
  - EDIT: EN=0, editing=1.
    - next: edit_pos decrements, wrapping 0 -> 6.
    - inc: the selected digit increments. Positions 6 and 4 (tens digits) wrap 5 -> 0; all other positions wrap 9 -> 0.
    - mode -> COMMIT. start is ignored.
  - COMMIT: load=1 for exactly LOAD_CYCLES cycles, then STOP with load=0. All keys are ignored.
- `preset` changes only through inc in EDIT and is stable throughout COMMIT. Every digit always holds a legal value.
- `blink`:
  - Set to 1 on the cycle EDIT is entered.
  - Then toggles every BLINK_HALF cycles while in EDIT.
  - Forced to 0 in all other states.
  - Its counter restarts on every next or inc press, so the newly selected or changed digit is shown solid first.
- `edit_pos` holds its value outside EDIT and is reloaded to 6 on each EDIT entry. Digit values are kept across edit sessions.

Optional Feature:
- Macro PRESET_DEC_KEY_EN.
- Defined:
  - Adds port `key_dec` (input, 1, raw, active-high) with the same conditioning as the other keys.
  - In EDIT, dec decrements the selected digit, wrapping 0 -> 5 for positions 6 and 4 and 0 -> 9 otherwise.
  - Priority becomes mode > start > next > inc > dec.
- Undefined: no `key_dec` port and no decrement logic; behaviour is exactly as above.

Test Plan:
1. Hold rst=0 with all keys toggling -> preset=0, load=0, EN=0, editing=0, blink=0, edit_pos=6. Release rst -> state STOP.
2. key_start bounces every 3 cycles for 15 cycles, then holds high 40 cycles (DEBOUNCE_MS=20) -> exactly one press; EN rises 1 at cycle 23 after the last edge (2 sync + 20 stable + 1 action). A second clean press -> EN=0.
3. mode, inc x7, next, inc x12, mode -> m1=1 (wraps at 5), m0=2. preset=28'h1200000 while load=1 for 1 cycle, then STOP and EN=0.
4. In EDIT, next x7 -> edit_pos walks 5,4,3,2,1,0,6. blink=1 at entry, 0 after 250 cycles, 1 after 500. A next press restarts the blink phase to 1.
5. In EDIT, mode and inc pulse the same cycle -> COMMIT, selected digit unchanged. In RUN, a mode press -> no state change, EN stays 1.
6. LOAD_CYCLES=4: assert rst=0 in the 2nd load cycle -> load=0 asynchronously before the next clock edge, preset=0, state STOP after release.

Source files
------------

// File: rtl/preset_editor.sv
// Button front end for the stopwatch: debounces keys, edits BCD preset digits, pulses load, drives EN.
// Optional PRESET_DEC_KEY_EN adds a key_dec input that decrements the selected digit.
module preset_editor #(
    parameter int DEBOUNCE_MS = 20,
    parameter int LOAD_CYCLES = 1,
    parameter int BLINK_HALF  = 250
) (
    input  logic        clk_1Khz,
    input  logic        rst,
    input  logic        key_start,
    input  logic        key_mode,
    input  logic        key_next,
    input  logic        key_inc,
`ifdef PRESET_DEC_KEY_EN
    input  logic        key_dec,
`endif
    output logic [27:0] preset,
    output logic        load,
    output logic        EN,
    output logic        editing,
    output logic [2:0]  edit_pos,
    output logic        blink
);

    localparam int KEY_START = 0;
    localparam int KEY_MODE  = 1;
    localparam int KEY_NEXT  = 2;
    localparam int KEY_INC   = 3;
`ifdef PRESET_DEC_KEY_EN
    localparam int KEY_DEC   = 4;
    localparam int NK        = 5;
`else
    localparam int NK        = 4;
`endif
    localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
    localparam int BL_W = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {STOP, RUN, EDIT, COMMIT} state_t;

    state_t          state, state_nxt;
    logic [NK-1:0]   keys;
    logic [NK-1:0]   sync_p0, sync_p1, deb, deb_d, press;
    logic [DB_W-1:0] db_cnt [NK];
    logic            mode_act, start_act, next_act, inc_act;
    logic [3:0]      digits [0:6];
    logic [3:0]      load_cnt;
    logic [BL_W-1:0] blink_cnt;
    logic            tens;

`ifdef PRESET_DEC_KEY_EN
    logic            dec_act;
    assign keys    = {key_dec, key_inc, key_next, key_mode, key_start};
    assign dec_act = press[KEY_DEC] & ~press[KEY_MODE] & ~press[KEY_START]
                   & ~press[KEY_NEXT] & ~press[KEY_INC];
`else
    assign keys = {key_inc, key_next, key_mode, key_start};
`endif

    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic is_tens);
        if (d >= (is_tens ? 4'd5 : 4'd9))
            return 4'd0;
        return d + 4'd1;
    endfunction

    function automatic logic [3:0] digit_dec(input logic [3:0] d, input logic is_tens);
        if (d == 4'd0)
            return is_tens ? 4'd5 : 4'd9;
        return d - 4'd1;
    endfunction

    // Key conditioning: 2-FF synchronizer, stability counter, rising-edge press pulse
    always_ff @(posedge clk_1Khz or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            deb     <= '0;
            deb_d   <= '0;
            for (int k = 0; k < NK; k++)
                db_cnt[k] <= '0;
        end else begin
            sync_p0 <= keys;
            sync_p1 <= sync_p0;
            deb_d   <= deb;
            for (int k = 0; k < NK; k++) begin
                if (sync_p1[k] == deb[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_W'(DEBOUNCE_MS - 1)) begin
                    db_cnt[k] <= '0;
                    deb[k]    <= sync_p1[k];
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign press = deb & ~deb_d;

    // Only the highest-priority press in a cycle is acted on
    assign mode_act  = press[KEY_MODE];
    assign start_act = press[KEY_START] & ~press[KEY_MODE];
    assign next_act  = press[KEY_NEXT] & ~press[KEY_MODE] & ~press[KEY_START];
    assign inc_act   = press[KEY_INC] & ~press[KEY_MODE] & ~press[KEY_START] & ~press[KEY_NEXT];

    always_ff @(posedge clk_1Khz or negedge rst) begin
        if (!rst)
            state <= STOP;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        EN        = 1'b0;
        editing   = 1'b0;
        load      = 1'b0;
        case (state)
            STOP: begin
                if (mode_act)
                    state_nxt = EDIT;
                else if (start_act)
                    state_nxt = RUN;
            end
            RUN: begin
                EN = 1'b1;
                if (start_act)
                    state_nxt = STOP;
            end
            EDIT: begin
                editing = 1'b1;
                if (mode_act)
                    state_nxt = COMMIT;
            end
            COMMIT: begin
                load = 1'b1;
                if (load_cnt == 4'(LOAD_CYCLES - 1))
                    state_nxt = STOP;
            end
            default: state_nxt = STOP;
        endcase
    end

    assign tens = (edit_pos == 3'd6) || (edit_pos == 3'd4);

    always_ff @(posedge clk_1Khz or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 7; i++)
                digits[i] <= 4'd0;
            edit_pos  <= 3'd6;
            blink     <= 1'b0;
            blink_cnt <= '0;
            load_cnt  <= 4'd0;
        end else begin
            load_cnt <= (state == COMMIT) ? load_cnt + 4'd1 : 4'd0;
            if (state == STOP && mode_act) begin
                edit_pos  <= 3'd6;
                blink     <= 1'b1;
                blink_cnt <= '0;
            end else if (state == EDIT && !mode_act) begin
                if (next_act)
                    edit_pos <= (edit_pos == 3'd0) ? 3'd6 : edit_pos - 3'd1;
                if (inc_act)
                    digits[edit_pos] <= digit_inc(digits[edit_pos], tens);
`ifdef PRESET_DEC_KEY_EN
                if (dec_act)
                    digits[edit_pos] <= digit_dec(digits[edit_pos], tens);
                if (next_act || inc_act || dec_act) begin
`else
                if (next_act || inc_act) begin
`endif
                    // A fresh selection or value is shown solid first
                    blink     <= 1'b1;
                    blink_cnt <= '0;
                end else if (blink_cnt == BL_W'(BLINK_HALF - 1)) begin
                    blink     <= ~blink;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else begin
                blink     <= 1'b0;
                blink_cnt <= '0;
            end
        end
    end

    assign preset = {digits[6], digits[5], digits[4], digits[3], digits[2], digits[1], digits[0]};

endmodule

// File: tb/tb_preset_editor.sv
// Directed bench for preset_editor: a default instance plus a LOAD_CYCLES=4 instance on shared inputs.
module tb_preset_editor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_start = 1'b0, key_mode = 1'b0, key_next = 1'b0, key_inc = 1'b0;
    logic [27:0] preset, preset4;
    logic        load, load4, en, en4, editing, editing4, blink, blink4;
    logic [2:0]  edit_pos, edit_pos4;
    int          n_cmp = 0;
    int          n_fail = 0;

    localparam int K_START = 0, K_MODE = 1, K_NEXT = 2, K_INC = 3;

    always #5 clk = ~clk;

    preset_editor dut (
        .clk_1Khz(clk), .rst(rst), .key_start(key_start), .key_mode(key_mode),
        .key_next(key_next), .key_inc(key_inc), .preset(preset), .load(load),
        .EN(en), .editing(editing), .edit_pos(edit_pos), .blink(blink)
    );

    preset_editor #(.LOAD_CYCLES(4)) dut4 (
        .clk_1Khz(clk), .rst(rst), .key_start(key_start), .key_mode(key_mode),
        .key_next(key_next), .key_inc(key_inc), .preset(preset4), .load(load4),
        .EN(en4), .editing(editing4), .edit_pos(edit_pos4), .blink(blink4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            K_START: key_start = v;
            K_MODE:  key_mode  = v;
            K_NEXT:  key_next  = v;
            default: key_inc   = v;
        endcase
    endtask

    // Press lands on the 23rd edge after the key rises (2 sync + 20 stable + 1 action)
    task automatic press(input int k);
        set_key(k, 1'b1);
        repeat (23) tick();
    endtask

    task automatic release_all();
        key_start = 1'b0; key_mode = 1'b0; key_next = 1'b0; key_inc = 1'b0;
        repeat (23) tick();
    endtask

    task automatic tap(input int k);
        press(k);
        release_all();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            key_start = i[0]; key_mode = i[1]; key_next = ~i[0]; key_inc = i[2];
            tick();
        end
        n_cmp++; if (preset !== 28'h0) begin n_fail++; $display("FAIL rst_preset: got %h want 0000000", preset); end
        n_cmp++; if (load !== 1'b0) begin n_fail++; $display("FAIL rst_load: got %b want 0", load); end
        n_cmp++; if (en !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %b want 0", en); end
        n_cmp++; if (editing !== 1'b0) begin n_fail++; $display("FAIL rst_editing: got %b want 0", editing); end
        n_cmp++; if (blink !== 1'b0) begin n_fail++; $display("FAIL rst_blink: got %b want 0", blink); end
        n_cmp++; if (edit_pos !== 3'd6) begin n_fail++; $display("FAIL rst_edit_pos: got %0d want 6", edit_pos); end
        key_start = 1'b0; key_mode = 1'b0; key_next = 1'b0; key_inc = 1'b0;
        tick();
        rst = 1'b1;
        repeat (5) tick();
        n_cmp++; if (en !== 1'b0 || editing !== 1'b0 || load !== 1'b0) begin
            n_fail++; $display("FAIL rst_release_stop: en=%b editing=%b load=%b want 0 0 0", en, editing, load);
        end
    endtask

    task automatic test_debounce();
        for (int i = 0; i < 5; i++) begin
            key_start = (i % 2 == 0);
            repeat (3) tick();
        end
        // key_start has been high for 3 edges since its last rising edge
        repeat (19) tick();
        n_cmp++; if (en !== 1'b0) begin n_fail++; $display("FAIL deb_early: EN=%b at 22 edges want 0", en); end
        tick();
        n_cmp++; if (en !== 1'b1) begin n_fail++; $display("FAIL deb_rise: EN=%b at 23 edges want 1", en); end
        repeat (17) tick();
        n_cmp++; if (en !== 1'b1) begin n_fail++; $display("FAIL deb_single: EN=%b after 40 high want 1", en); end
        release_all();
        press(K_START);
        n_cmp++; if (en !== 1'b0) begin n_fail++; $display("FAIL deb_stop: EN=%b want 0", en); end
        release_all();
    endtask

    task automatic test_edit_commit();
        press(K_MODE);
        n_cmp++; if (editing !== 1'b1 || edit_pos !== 3'd6) begin
            n_fail++; $display("FAIL edit_enter: editing=%b pos=%0d want 1 6", editing, edit_pos);
        end
        release_all();
        repeat (7) tap(K_INC);
        n_cmp++; if (preset !== 28'h1000000) begin n_fail++; $display("FAIL inc_tens_wrap: got %h want 1000000", preset); end
        tap(K_NEXT);
        n_cmp++; if (edit_pos !== 3'd5) begin n_fail++; $display("FAIL next_pos: got %0d want 5", edit_pos); end
        repeat (12) tap(K_INC);
        n_cmp++; if (preset !== 28'h1200000) begin n_fail++; $display("FAIL inc_units_wrap: got %h want 1200000", preset); end
        press(K_MODE);
        n_cmp++; if (load !== 1'b1 || preset !== 28'h1200000) begin
            n_fail++; $display("FAIL commit_load: load=%b preset=%h want 1 1200000", load, preset);
        end
        n_cmp++; if (en !== 1'b0 || editing !== 1'b0) begin
            n_fail++; $display("FAIL commit_flags: en=%b editing=%b want 0 0", en, editing);
        end
        tick();
        n_cmp++; if (load !== 1'b0) begin n_fail++; $display("FAIL load_width1: load=%b want 0", load); end
        n_cmp++; if (load4 !== 1'b1) begin n_fail++; $display("FAIL load4_c2: load=%b want 1", load4); end
        repeat (2) tick();
        n_cmp++; if (load4 !== 1'b1) begin n_fail++; $display("FAIL load4_c4: load=%b want 1", load4); end
        tick();
        n_cmp++; if (load4 !== 1'b0) begin n_fail++; $display("FAIL load4_end: load=%b want 0", load4); end
        release_all();
        tap(K_INC);
        n_cmp++; if (preset !== 28'h1200000 || en !== 1'b0 || editing !== 1'b0) begin
            n_fail++; $display("FAIL stop_ignores_inc: preset=%h en=%b editing=%b want 1200000 0 0", preset, en, editing);
        end
    endtask

    task automatic test_edit_pos_blink();
        logic [2:0] exp_pos [6];
        exp_pos = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd6};
        press(K_MODE);
        n_cmp++; if (blink !== 1'b1 || edit_pos !== 3'd6) begin
            n_fail++; $display("FAIL blink_entry: blink=%b pos=%0d want 1 6", blink, edit_pos);
        end
        key_mode = 1'b0;
        repeat (249) tick();
        n_cmp++; if (blink !== 1'b1) begin n_fail++; $display("FAIL blink_249: got %b want 1", blink); end
        tick();
        n_cmp++; if (blink !== 1'b0) begin n_fail++; $display("FAIL blink_250: got %b want 0", blink); end
        repeat (250) tick();
        n_cmp++; if (blink !== 1'b1) begin n_fail++; $display("FAIL blink_500: got %b want 1", blink); end
        repeat (250) tick();
        press(K_NEXT);
        n_cmp++; if (blink !== 1'b1 || edit_pos !== 3'd5) begin
            n_fail++; $display("FAIL blink_restart: blink=%b pos=%0d want 1 5", blink, edit_pos);
        end
        release_all();
        for (int i = 0; i < 6; i++) begin
            tap(K_NEXT);
            n_cmp++; if (edit_pos !== exp_pos[i]) begin
                n_fail++; $display("FAIL pos_walk_%0d: got %0d want %0d", i, edit_pos, exp_pos[i]);
            end
        end
        tap(K_MODE);
        n_cmp++; if (preset !== 28'h1200000 || blink !== 1'b0) begin
            n_fail++; $display("FAIL walk_commit: preset=%h blink=%b want 1200000 0", preset, blink);
        end
    endtask

    task automatic test_priority();
        tap(K_MODE);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        repeat (23) tick();
        n_cmp++; if (load !== 1'b1 || preset !== 28'h1200000) begin
            n_fail++; $display("FAIL mode_over_inc: load=%b preset=%h want 1 1200000", load, preset);
        end
        release_all();
        tap(K_START);
        n_cmp++; if (en !== 1'b1) begin n_fail++; $display("FAIL run_enter: EN=%b want 1", en); end
        press(K_MODE);
        n_cmp++; if (en !== 1'b1 || editing !== 1'b0) begin
            n_fail++; $display("FAIL run_ignores_mode: en=%b editing=%b want 1 0", en, editing);
        end
        release_all();
        tap(K_START);
        n_cmp++; if (en !== 1'b0) begin n_fail++; $display("FAIL run_exit: EN=%b want 0", en); end
    endtask

    task automatic test_reset_mid_load();
        tap(K_MODE);
        tap(K_INC);
        n_cmp++; if (preset4 !== 28'h2200000) begin n_fail++; $display("FAIL pre_load4_preset: got %h want 2200000", preset4); end
        press(K_MODE);
        tick();
        n_cmp++; if (load4 !== 1'b1) begin n_fail++; $display("FAIL load4_second: load=%b want 1", load4); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (load4 !== 1'b0) begin n_fail++; $display("FAIL async_load_drop: load=%b want 0", load4); end
        n_cmp++; if (preset4 !== 28'h0 || edit_pos4 !== 3'd6 || en4 !== 1'b0) begin
            n_fail++; $display("FAIL async_clear: preset=%h pos=%0d en=%b want 0000000 6 0", preset4, edit_pos4, en4);
        end
        key_start = 1'b0; key_mode = 1'b0; key_next = 1'b0; key_inc = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++; if (load4 !== 1'b0 || editing4 !== 1'b0) begin
            n_fail++; $display("FAIL post_rst_idle: load=%b editing=%b want 0 0", load4, editing4);
        end
        tap(K_START);
        n_cmp++; if (en4 !== 1'b1) begin n_fail++; $display("FAIL post_rst_stop: EN=%b want 1", en4); end
        tap(K_START);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_edit_commit();
        test_edit_pos_blink();
        test_priority();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
